// File: rtl/serial_word_transmitter_if.sv
// Parallel-load / serial-out handshake bundle for serial_word_transmitter.
// The producer uses the master modport; the transmitter uses the slave modport.
interface serial_word_transmitter_if #(
    parameter int N = 8
);
    logic [N-1:0] din;
    logic         load_valid;
    logic         load_ready;
    logic         serial_out;
    logic         shift_en;
    logic         busy;
    logic         done;

    modport master (
        output din, load_valid,
        input  load_ready, serial_out, shift_en, busy, done
    );

    modport slave (
        input  din, load_valid,
        output load_ready, serial_out, shift_en, busy, done
    );
endinterface

// File: rtl/serial_word_transmitter.sv
// Parallel-in/serial-out word transmitter with a programmable bit period and a sample strobe.
// Optional even-parity trailer bit is enabled by defining SERIAL_TX_PARITY_EN.
module serial_word_transmitter #(
    parameter int N         = 8,
    parameter int DIV       = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    serial_word_transmitter_if.slave   bus
);
`ifdef SERIAL_TX_PARITY_EN
    localparam int W = N + 1;
`else
    localparam int W = N;
`endif
    localparam int BW  = (W > 1) ? $clog2(W) : 1;
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam bit MSB = (MSB_FIRST != 0);

    localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  shreg_q, shreg_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          serial_out_q, serial_out_d;
    logic          shift_en_q, shift_en_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic [W-1:0]  load_word;

    // Parity sits at the far end of the shift register so it leaves after the data bits.
`ifdef SERIAL_TX_PARITY_EN
    assign load_word = MSB ? {bus.din, ^bus.din} : {^bus.din, bus.din};
`else
    assign load_word = bus.din;
`endif

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.load_valid) begin
                    shreg_d   = load_word;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    shreg_d   = MSB ? (shreg_q << 1) : (shreg_q >> 1);
                    if (bit_cnt_q == BIT_LAST)
                        state_d = DONE;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_comb begin
        serial_out_d = (state_d == SHIFT) && (MSB ? shreg_d[W-1] : shreg_d[0]);
        shift_en_d   = (state_d == SHIFT) && (div_cnt_d == DIV_LAST);
        done_d       = (state_d == DONE);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            div_cnt_q    <= '0;
            serial_out_q <= 1'b0;
            shift_en_q   <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            div_cnt_q    <= div_cnt_d;
            serial_out_q <= serial_out_d;
            shift_en_q   <= shift_en_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.load_ready = (state_q == IDLE);
    assign bus.serial_out = serial_out_q;
    assign bus.shift_en   = shift_en_q;
    assign bus.done       = done_q;
    assign bus.busy       = busy_q;
endmodule
